mesh_term_arb_fifo: RTL and testbench
=====================================

Name: mesh_term_arb_fifo

Overview:
- Multi-terminal ingress buffer for the mesh.
- NUM_CH terminal agents each push packets into a private FIFO (PCKG_SZ wide, FIFO_DEPTH deep).
- A round-robin arbiter drains the non-empty FIFOs into one registered output stage, which presents the mesh-side pndng/pop handshake.
- Generalises the single-port terminal FIFO to N channels with arbitration, overflow reporting and occupancy outputs.

Parameters:
- PCKG_SZ, 40, packet width in bits.
- FIFO_DEPTH, 4, entries per channel FIFO (>=2).
- NUM_CH, 4, number of terminal channels (>=2).
- CH_W, $clog2(NUM_CH), width of the channel-select field (derived localparam).
- CNT_W, $clog2(FIFO_DEPTH+1), width of the occupancy counter (derived localparam).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  NUM_CH  per-channel write strobe.
- data_in  in  NUM_CH*PCKG_SZ  per-channel packets; channel c occupies bits [c*PCKG_SZ +: PCKG_SZ].
- full  out  NUM_CH  channel FIFO holds FIFO_DEPTH entries.
- count  out  NUM_CH*CNT_W  per-channel occupancy; excludes the output register.
- overflow  out  NUM_CH  sticky: a push was dropped on this channel.
- data_out  out  PCKG_SZ  packet in the output register.
- src_ch  out  CH_W  channel the data_out packet came from.
- pndng  out  1  output register holds a valid packet.
- pop  in  1  mesh consumes data_out.

Behaviour:
- Reset (reset=0, asynchronous): all FIFOs emptied; full, count, overflow, pndng and src_ch = 0; data_out = 0; round-robin pointer = 0.
  - pndng must fall within the reset assertion, with no clock needed.
  - Reset mid-operation discards all buffered and in-flight packets.
- Push:
  - Accepted on a rising edge iff push[c]=1 and count[c] < FIFO_DEPTH.
  - Push while full is dropped and sets overflow[c]=1. This holds even if the same channel is drained that cycle.
  - overflow clears only on reset.
- Pop: honoured only when pndng=1. Pop while pndng=0 is ignored with no state change.
- Output register load: on each edge the register loads when it is empty, or when pndng=1 and pop=1.
  - Load source is the arbitration winner among channels with count>0.
  - Loading dequeues the winner's head entry, sets src_ch, and sets pndng=1.
  - If no channel is non-empty, pndng=0 after the edge.
- Latency:
  - Push sampled at edge E0 into an empty block: pndng=1 and data_out valid after E1.
  - Throughput is 1 packet/cycle with pop held high.
- Arbitration:
  - Round-robin: search starts at pointer p and wraps modulo NUM_CH.
  - After a grant to channel g, p = (g+1) mod NUM_CH.
  - Non-empty channels are served in at most NUM_CH grants (no starvation).
- Same channel, same edge:
  - Push to an empty channel and dequeue do not bypass; the packet becomes eligible the next edge.
  - Push and dequeue on a non-full channel leave count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. count is exact for 0..FIFO_DEPTH.
- No combinational path from push/data_in to data_out/pndng.

Optional Feature:
- MESH_ARB_STATS_EN defined adds:
  - output grant_cnt, NUM_CH*16 bits: per-channel count of packets popped by the mesh; wraps at 2^16; reset to 0.
  - output drop_cnt, NUM_CH*16 bits: per-channel count of dropped pushes; saturates at 16'hFFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mesh_arb_pkg:
  - packet field localparams (target row/column positions at the MSBs of a PCKG_SZ packet);
  - typedef pkt_t for a PCKG_SZ logic vector;
  - function rr_next(pointer, request vector) returning the grant index.
- Sub-module mesh_term_fifo: single-channel FIFO with push/dequeue/full/count/overflow, instantiated NUM_CH times via generate.
- Arbiter and output register live in the top module.

Test Plan:
- Single push, ch2, data 40'hA5_0000_0001, pop held high:
  - pndng=1 one cycle after the push edge;
  - data_out=40'hA5_0000_0001 and src_ch=2;
  - pndng=0 after the pop edge.
- All 4 channels push one packet each in the same cycle, pop=1 continuously: src_ch sequence 0,1,2,3 on consecutive cycles, then pndng=0.
- Ch0 pushes 5 packets with pop=0 (FIFO_DEPTH=4):
  - the first fills the output register, so count[0]=4 and full[0]=1 after the fifth;
  - a sixth push is dropped with overflow[0]=1;
  - 5 pops return the first 5 packets in order.
- Ch1 and ch3 each hold 3 packets, pop=1: grants alternate 1,3,1,3,1,3. Pointer wrap is verified.
- Reset asserted while 3 channels hold data and pndng=1:
  - pndng, full, count and overflow = 0 immediately, without a clock edge;
  - after release, a pop with no pushes leaves pndng=0.
- With MESH_ARB_STATS_EN defined, run the overflow scenario: drop_cnt[0]=1 and grant_cnt[0]=5 after all pops.

Source files
------------

// File: rtl/mesh_term_arb_fifo_pkg.sv
// Shared packet types and round-robin helper for the mesh terminal arbiter FIFO.
package mesh_arb_pkg;

  localparam int PKT_W       = 40;
  localparam int TGT_ROW_W   = 4;
  localparam int TGT_COL_W   = 4;
  localparam int TGT_ROW_MSB = PKT_W - 1;
  localparam int TGT_ROW_LSB = PKT_W - TGT_ROW_W;
  localparam int TGT_COL_MSB = TGT_ROW_LSB - 1;
  localparam int TGT_COL_LSB = TGT_ROW_LSB - TGT_COL_W;
  localparam int MAX_CH      = 32;

  typedef logic [PKT_W-1:0] pkt_t;

  // First requester at or after ptr, wrapping modulo nch; 0 when nothing requests.
  function automatic int rr_next(input int ptr, input logic [MAX_CH-1:0] req, input int nch);
    int   idx;
    int   gnt;
    logic found;
    gnt   = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < nch) begin
        idx = ptr + i;
        if (idx >= nch) idx = idx - nch;
        if (!found && req[idx]) begin
          found = 1'b1;
          gnt   = idx;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mesh_term_arb_fifo_if.sv
// Terminal/mesh-side bundle of the arbiter FIFO; MESH_ARB_STATS_EN adds the per-channel
// grant/drop counters. master = terminals + mesh, slave = the buffer block.
interface mesh_term_arb_fifo_if #(
  parameter int NUM_CH     = 4,
  parameter int PCKG_SZ    = 40,
  parameter int FIFO_DEPTH = 4
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_CH-1:0]         push;
  logic [NUM_CH*PCKG_SZ-1:0] data_in;
  logic [NUM_CH-1:0]         full;
  logic [NUM_CH*CNT_W-1:0]   count;
  logic [NUM_CH-1:0]         overflow;
  logic [PCKG_SZ-1:0]        data_out;
  logic [CH_W-1:0]           src_ch;
  logic                      pndng;
  logic                      pop;
`ifdef MESH_ARB_STATS_EN
  logic [NUM_CH*16-1:0]      grant_cnt;
  logic [NUM_CH*16-1:0]      drop_cnt;
`endif

  modport master (
    output push, data_in, pop,
    input  full, count, overflow, data_out, src_ch, pndng
`ifdef MESH_ARB_STATS_EN
    , input grant_cnt, drop_cnt
`endif
  );

  modport slave (
    input  push, data_in, pop,
    output full, count, overflow, data_out, src_ch, pndng
`ifdef MESH_ARB_STATS_EN
    , output grant_cnt, drop_cnt
`endif
  );

endinterface

// File: rtl/mesh_term_arb_fifo_fifo.sv
// Single-channel terminal FIFO: head visible combinationally, dequeue takes effect on the edge.
// A push while full is dropped and latches a sticky overflow flag until reset.
module mesh_term_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [W-1:0]     i_dat,
  input  logic             i_deq,
  output logic [W-1:0]     o_head,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [AW-1:0]   C_LAST  = AW'(DEPTH - 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_full;
  logic             w_acc;
  logic             w_deq;

  // Acceptance looks only at the pre-edge count, so a same-edge dequeue never frees a slot.
  assign w_full = (r_cnt == C_DEPTH);
  assign w_acc  = i_push && !w_full;
  assign w_deq  = i_deq && (r_cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_acc) r_wr <= (r_wr == C_LAST) ? '0 : r_wr + 1'b1;
      if (w_deq) r_rd <= (r_rd == C_LAST) ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CNT_W'(w_acc) - CNT_W'(w_deq);
      if (i_push && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wr] <= i_dat;
  end

  assign o_head     = r_mem[r_rd];
  assign o_full     = w_full;
  assign o_count    = r_cnt;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/mesh_term_arb_fifo.sv
// N-channel terminal ingress buffer: round-robin drain into a registered pndng/pop stage, one cycle
// push-to-pndng, 1 pkt/cycle under pop; full channels drop pushes. MESH_ARB_STATS_EN adds grant/drop counters.
module mesh_term_arb_fifo
  import mesh_arb_pkg::*;
#(
  parameter int PCKG_SZ    = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_CH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mesh_term_arb_fifo_if.slave    bus
);
  localparam int              CH_W      = $clog2(NUM_CH);
  localparam int              CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(NUM_CH - 1);

  logic [PCKG_SZ-1:0]      w_head [NUM_CH];
  logic [NUM_CH-1:0]       w_req;
  logic [NUM_CH-1:0]       w_deq;
  logic [NUM_CH-1:0]       w_full;
  logic [NUM_CH-1:0]       w_ovf;
  logic [NUM_CH*CNT_W-1:0] w_count;
  logic                    w_load;
  logic                    w_any;
  logic [CH_W-1:0]         w_gnt;

  logic [PCKG_SZ-1:0]      r_dat;
  logic [CH_W-1:0]         r_src;
  logic [CH_W-1:0]         r_ptr;
  logic                    r_pndng;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mesh_term_fifo #(
      .W     (PCKG_SZ),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (bus.push[c]),
      .i_dat      (bus.data_in[c*PCKG_SZ +: PCKG_SZ]),
      .i_deq      (w_deq[c]),
      .o_head     (w_head[c]),
      .o_full     (w_full[c]),
      .o_count    (w_count[c*CNT_W +: CNT_W]),
      .o_overflow (w_ovf[c])
    );
    assign w_req[c] = (w_count[c*CNT_W +: CNT_W] != '0);
    assign w_deq[c] = w_load && w_any && (w_gnt == CH_W'(c));
  end

  // The output stage refills whenever it is empty or being consumed this edge.
  assign w_load = !r_pndng || bus.pop;
  assign w_any  = |w_req;
  assign w_gnt  = CH_W'(rr_next(int'(r_ptr), MAX_CH'(w_req), NUM_CH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dat   <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_pndng <= 1'b0;
    end else if (w_load) begin
      r_pndng <= w_any;
      if (w_any) begin
        r_dat <= w_head[w_gnt];
        r_src <= w_gnt;
        r_ptr <= (w_gnt == C_LAST_CH) ? '0 : w_gnt + 1'b1;
      end
    end
  end

  assign bus.full     = w_full;
  assign bus.overflow = w_ovf;
  assign bus.count    = w_count;
  assign bus.data_out = r_dat;
  assign bus.src_ch   = r_src;
  assign bus.pndng    = r_pndng;

`ifdef MESH_ARB_STATS_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_stats
    logic [15:0] r_grant;
    logic [15:0] r_drop;
    // Grants wrap freely; drops saturate so a stuck terminal stays visible.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_grant <= '0;
        r_drop  <= '0;
      end else begin
        if (r_pndng && bus.pop && (r_src == CH_W'(c))) r_grant <= r_grant + 16'd1;
        if (bus.push[c] && w_full[c] && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      end
    end
    assign bus.grant_cnt[c*16 +: 16] = r_grant;
    assign bus.drop_cnt[c*16 +: 16]  = r_drop;
  end
`endif

endmodule

// File: tb/tb_mesh_term_arb_fifo.sv
// Bench for mesh_term_arb_fifo: vector table, hand-written corner sequences, and a randomized
// run against a list-based reference model; MESH_ARB_STATS_EN also checks the counters.
module tb_mesh_term_arb_fifo;
  import mesh_arb_pkg::*;

  localparam int NCH = 4;
  localparam int DEP = 4;
  localparam int W   = 40;
  localparam int CW  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mesh_term_arb_fifo_if #(.NUM_CH(NCH), .PCKG_SZ(W), .FIFO_DEPTH(DEP)) bus ();

  mesh_term_arb_fifo #(.PCKG_SZ(W), .FIFO_DEPTH(DEP), .NUM_CH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit             rst;
    logic [NCH-1:0] push;
    pkt_t           base;
    bit             pop;
    bit             e_pndng;
    logic [1:0]     e_src;
    pkt_t           e_dat;
  } vec_t;

  vec_t tbl [18];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: per-channel ordered lists plus one output slot.
  pkt_t           m_buf [NCH][DEP];
  int             m_n   [NCH];
  bit             m_vld;
  pkt_t           m_dat;
  int             m_src;
  int             m_ptr;
  bit [NCH-1:0]   m_ovf;
  int             m_grant [NCH];
  int             m_drop  [NCH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_n[c] = 0;
      m_grant[c] = 0;
      m_drop[c] = 0;
    end
    m_vld = 1'b0;
    m_dat = '0;
    m_src = 0;
    m_ptr = 0;
    m_ovf = '0;
  endtask

  task automatic model_edge(input logic [NCH-1:0] p, input logic [NCH*W-1:0] d, input logic pp);
    bit acc [NCH];
    bit found;
    for (int c = 0; c < NCH; c++) begin
      acc[c] = p[c] && (m_n[c] < DEP);
      if (p[c] && !acc[c]) begin
        m_ovf[c] = 1'b1;
        if (m_drop[c] < 65535) m_drop[c]++;
      end
    end
    if (m_vld && pp) m_grant[m_src] = (m_grant[m_src] + 1) % 65536;
    if (!m_vld || pp) begin
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = (m_ptr + i) % NCH;
        if (!found && m_n[c] > 0) begin
          found = 1'b1;
          m_dat = m_buf[c][0];
          for (int j = 0; j < DEP - 1; j++) m_buf[c][j] = m_buf[c][j+1];
          m_n[c]--;
          m_src = c;
          m_ptr = (c + 1) % NCH;
        end
      end
      m_vld = found;
    end
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        m_buf[c][m_n[c]] = d[c*W +: W];
        m_n[c]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(bus.push, bus.data_in, bus.pop);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] p, input pkt_t base, input logic pp);
    bus.push = p;
    bus.pop  = pp;
    for (int c = 0; c < NCH; c++) bus.data_in[c*W +: W] = base + pkt_t'(c);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.push = '0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    #3;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_model();
    logic [NCH*CW-1:0] ec;
    logic [NCH-1:0]    ef;
    for (int c = 0; c < NCH; c++) begin
      ec[c*CW +: CW] = CW'(m_n[c]);
      ef[c] = (m_n[c] == DEP);
    end
    chk("rnd.pndng", 64'(bus.pndng), 64'(m_vld));
    if (m_vld) begin
      chk("rnd.data", 64'(bus.data_out), 64'(m_dat));
      chk("rnd.src", 64'(bus.src_ch), 64'(m_src));
    end
    chk("rnd.count", 64'(bus.count), 64'(ec));
    chk("rnd.full", 64'(bus.full), 64'(ef));
    chk("rnd.ovf", 64'(bus.overflow), 64'(m_ovf));
`ifdef MESH_ARB_STATS_EN
    for (int c = 0; c < NCH; c++) begin
      chk("rnd.grant", 64'(bus.grant_cnt[c*16 +: 16]), 64'(m_grant[c]));
      chk("rnd.drop", 64'(bus.drop_cnt[c*16 +: 16]), 64'(m_drop[c]));
    end
`endif
  endtask

  initial begin
    // rst push base pop | pndng src data
    tbl[0]  = '{1'b1, 4'hF, 40'h10_0000_0000, 1'b1, 1'b0, 2'd0, 40'h0};
    tbl[1]  = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd0, 40'h10_0000_0000};
    tbl[2]  = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd1, 40'h10_0000_0001};
    tbl[3]  = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd2, 40'h10_0000_0002};
    tbl[4]  = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd3, 40'h10_0000_0003};
    tbl[5]  = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b0, 2'd0, 40'h0};
    tbl[6]  = '{1'b1, 4'h4, 40'hA4_FFFF_FFFF, 1'b1, 1'b0, 2'd0, 40'h0};
    tbl[7]  = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd2, 40'hA5_0000_0001};
    tbl[8]  = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b0, 2'd0, 40'h0};
    tbl[9]  = '{1'b1, 4'hA, 40'h30_0000_0000, 1'b0, 1'b0, 2'd0, 40'h0};
    tbl[10] = '{1'b0, 4'hA, 40'h31_0000_0000, 1'b0, 1'b1, 2'd1, 40'h30_0000_0001};
    tbl[11] = '{1'b0, 4'hA, 40'h32_0000_0000, 1'b0, 1'b1, 2'd1, 40'h30_0000_0001};
    tbl[12] = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd3, 40'h30_0000_0003};
    tbl[13] = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd1, 40'h31_0000_0001};
    tbl[14] = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd3, 40'h31_0000_0003};
    tbl[15] = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd1, 40'h32_0000_0001};
    tbl[16] = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b1, 2'd3, 40'h32_0000_0003};
    tbl[17] = '{1'b0, 4'h0, 40'h0,            1'b1, 1'b0, 2'd0, 40'h0};

    bus.push = '0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst.pndng", 64'(bus.pndng), 64'(1'b0));
    chk("rst.data", 64'(bus.data_out), 64'(0));
    chk("rst.src", 64'(bus.src_ch), 64'(0));
    chk("rst.full", 64'(bus.full), 64'(0));
    chk("rst.count", 64'(bus.count), 64'(0));
    chk("rst.ovf", 64'(bus.overflow), 64'(0));
    #2 reset = 1'b1;
    step();

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].push, tbl[i].base, tbl[i].pop);
      step();
      chk($sformatf("tbl%0d.pndng", i), 64'(bus.pndng), 64'(tbl[i].e_pndng));
      if (tbl[i].e_pndng) begin
        chk($sformatf("tbl%0d.src", i), 64'(bus.src_ch), 64'(tbl[i].e_src));
        chk($sformatf("tbl%0d.data", i), 64'(bus.data_out), 64'(tbl[i].e_dat));
      end
    end

    // Ch0 overfill with the mesh stalled, then drain in order.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 40'hD0_0000_0000 + pkt_t'(k), 1'b0);
      step();
    end
    chk("ovf.count4", 64'(bus.count[2:0]), 64'(4));
    chk("ovf.full", 64'(bus.full[0]), 64'(1'b1));
    chk("ovf.noovf", 64'(bus.overflow[0]), 64'(1'b0));
    drive(4'b0001, 40'hD0_0000_0005, 1'b0);
    step();
    chk("ovf.sticky", 64'(bus.overflow[0]), 64'(1'b1));
    chk("ovf.count_hold", 64'(bus.count[2:0]), 64'(4));
    drive(4'b0000, 40'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ovf.pop%0d.pndng", k), 64'(bus.pndng), 64'(1'b1));
      chk($sformatf("ovf.pop%0d.data", k), 64'(bus.data_out), 64'(40'hD0_0000_0000 + pkt_t'(k)));
      step();
    end
    chk("ovf.drained", 64'(bus.pndng), 64'(1'b0));
    chk("ovf.ovf_kept", 64'(bus.overflow[0]), 64'(1'b1));
`ifdef MESH_ARB_STATS_EN
    chk("stats.grant0", 64'(bus.grant_cnt[15:0]), 64'(5));
    chk("stats.drop0", 64'(bus.drop_cnt[15:0]), 64'(1));
`endif

    // Asynchronous reset mid-operation with three channels loaded.
    drive(4'b0111, 40'hE0_0000_0000, 1'b0);
    step();
    step();
    chk("arst.pre_pndng", 64'(bus.pndng), 64'(1'b1));
    reset = 1'b0;
    #2;
    chk("arst.pndng", 64'(bus.pndng), 64'(1'b0));
    chk("arst.full", 64'(bus.full), 64'(0));
    chk("arst.count", 64'(bus.count), 64'(0));
    chk("arst.ovf", 64'(bus.overflow), 64'(0));
    chk("arst.data", 64'(bus.data_out), 64'(0));
    reset = 1'b1;
    model_reset();
    drive(4'b0000, 40'h0, 1'b1);
    step();
    chk("arst.idle_pop", 64'(bus.pndng), 64'(1'b0));
    chk("arst.idle_count", 64'(bus.count), 64'(0));

    // Randomized traffic: heavy backpressure first, then mostly draining.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.push = NCH'($urandom);
      bus.pop  = ($urandom_range(0, 99) < ((cyc < 1500) ? 30 : 85));
      for (int c = 0; c < NCH; c++) bus.data_in[c*W +: W] = pkt_t'({$urandom, $urandom});
      step();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
